// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: latches up to NSRC requests, masks and
// prioritises them, and drives one irq line with an intack / EOI handshake.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    input  logic [NSRC-1:0] src,
    input  logic            intack,
    output logic            irq,
    output logic [2:0]      irq_id,
    output logic [1:0]      dbg_state
);

    // Handshake: irq stays high while a request is offered; the CPU answers with
    // a one-cycle intack pulse, and a later write to EOI closes the service window.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_mode_q, edge_mode_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] src_prev_q;
    logic            gie_q, gie_d;
    logic [2:0]      cur_id_q, cur_id_d;

    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic [2:0]      best;
    logic            ack;
    logic            eoi;
    logic            unused_din;

    assign unused_din = ^{din[31:NSRC+16], din[15:NSRC]};

    assign elig = gie_q ? (pend_q & mask_q) : '0;
    assign ack  = (state_q == ST_REQ) && intack && (elig != '0);
    assign eoi  = we && (addr == 2'd3);
    assign w1c  = (we && (addr == 2'd1)) ? din[NSRC-1:0] : '0;

    always_comb begin
        best = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) best = 3'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = ack && (best == 3'(i));
        end
    end

    // A fresh edge always wins over a clear landing in the same cycle.
    assign pend_d = (edge_mode_q & ((src & ~src_prev_q) | (pend_q & ~(w1c | ack_clr))))
                  | (~edge_mode_q & src);

    always_comb begin
        mask_d      = mask_q;
        edge_mode_d = edge_mode_q;
        gie_d       = gie_q;
        if (we && (addr == 2'd0)) mask_d = din[NSRC-1:0];
        if (we && (addr == 2'd2)) begin
            gie_d       = din[0];
            edge_mode_d = din[NSRC+15:16];
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            ST_IDLE: begin
                if (elig != '0) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (elig == '0) begin
                    state_d = ST_IDLE;
                end else if (intack) begin
                    state_d  = ST_SERVICE;
                    cur_id_d = best;
                end
            end
            ST_SERVICE: begin
                if (eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            edge_mode_q <= '0;
            pend_q      <= '0;
            src_prev_q  <= '0;
            gie_q       <= 1'b0;
            cur_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            edge_mode_q <= edge_mode_d;
            pend_q      <= pend_d;
            src_prev_q  <= src;
            gie_q       <= gie_d;
            cur_id_q    <= cur_id_d;
        end
    end

    assign irq       = (state_q == ST_REQ);
    assign irq_id    = (state_q == ST_REQ) ? best : cur_id_q;
    assign dbg_state = state_q;

    always_comb begin
        dout = '0;
        case (addr)
            2'd0: dout[NSRC-1:0] = mask_q;
            2'd1: dout[NSRC-1:0] = pend_q;
            2'd2: begin
                dout[0]           = gie_q;
                dout[1]           = (state_q == ST_SERVICE);
                dout[2]           = (state_q == ST_REQ);
                dout[10:8]        = cur_id_q;
                dout[NSRC+15:16]  = edge_mode_q;
            end
            2'd3: dout[2:0] = cur_id_q;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the controller.
module tb_irq_ctrl;

    localparam int NSRC = 6;

    logic            clk;
    logic            rst;
    logic [1:0]      addr;
    logic            we;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic [NSRC-1:0] src;
    logic            intack;
    logic            irq;
    logic [2:0]      irq_id;
    logic [1:0]      dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din), .dout(dout),
        .src(src), .intack(intack), .irq(irq), .irq_id(irq_id),
        .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: phase 0 idle, 1 requesting, 2 in service.
    bit [NSRC-1:0] m_mask, m_edge, m_pend, m_prev;
    bit            m_gie;
    int            m_phase;
    int            m_cur;

    function automatic int first_set(input bit [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [NSRC-1:0] m_elig();
        return m_gie ? (m_pend & m_mask) : '0;
    endfunction

    task automatic model_reset();
        m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0;
        m_gie = 1'b0; m_phase = 0; m_cur = 0;
    endtask

    task automatic model_step();
        bit [NSRC-1:0] np;
        int b;
        bit taken;
        if (!rst) begin
            model_reset();
            return;
        end
        b = first_set(m_elig());
        taken = (m_phase == 1) && intack && (b >= 0);
        for (int i = 0; i < NSRC; i++) begin
            if (!m_edge[i])                            np[i] = src[i];
            else if (src[i] && !m_prev[i])             np[i] = 1'b1;
            else if ((we && addr == 2'd1 && din[i]) || (taken && b == i)) np[i] = 1'b0;
            else                                       np[i] = m_pend[i];
        end
        if (m_phase == 0) begin
            if (b >= 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (b < 0) m_phase = 0;
            else if (taken) begin m_phase = 2; m_cur = b; end
        end else if (we && addr == 2'd3) begin
            m_phase = 0;
        end
        if (we && addr == 2'd0) m_mask = din[NSRC-1:0];
        if (we && addr == 2'd2) begin m_gie = din[0]; m_edge = din[NSRC+15:16]; end
        m_pend = np;
        m_prev = src;
    endtask

    function automatic logic [31:0] exp_dout(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: v[NSRC-1:0] = m_mask;
            2'd1: v[NSRC-1:0] = m_pend;
            2'd2: v = (32'(m_edge) << 16) | (32'(m_cur) << 8) | (32'(m_phase == 1) << 2)
                    | (32'(m_phase == 2) << 1) | 32'(m_gie);
            default: v = 32'(m_cur);
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model follows the posedge, outputs are compared on the negedge.
    task automatic cycle();
        int b;
        @(posedge clk);
        model_step();
        @(negedge clk);
        b = first_set(m_elig());
        chk("irq", irq, 32'(m_phase == 1));
        if (m_phase != 1) chk("irq_id", irq_id, 32'(m_cur));
        else if (b >= 0)  chk("irq_id", irq_id, 32'(b));
        chk("dout", dout, exp_dout(addr));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; din = d; we = 1'b1;
        cycle();
        we = 1'b0; din = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    task automatic do_reset();
        src = '0; we = 1'b0; intack = 1'b0; addr = '0; din = '0;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_irq", irq, 0);
        chk("rst_irq_id", irq_id, 0);
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; src = '0; we = 1'b0; intack = 1'b0; addr = '0; din = '0;
        model_reset();
        @(negedge clk);

        // Basic edge source flow
        do_reset();
        for (int a = 0; a < 4; a++) rd_chk("rst_dout", 2'(a), 32'h0);
        wr(2'd0, 32'h1);
        wr(2'd2, 32'h0001_0001);
        src[0] = 1'b1;
        cycle();
        chk("t1_lat", irq, 0);
        cycle();
        chk("t1_irq", irq, 1);
        chk("t1_id", irq_id, 0);
        intack = 1'b1;
        cycle();
        intack = 1'b0;
        chk("t1_ack_irq", irq, 0);
        rd_chk("t1_cfg_svc", 2'd2, 32'h0001_0003);
        rd_chk("t1_pend", 2'd1, 32'h0);
        wr(2'd3, 32'h0);
        chk("t1_eoi_irq", irq, 0);
        rd_chk("t1_cfg_idle", 2'd2, 32'h0001_0001);
        cycle();
        chk("t1_quiet", irq, 0);

        // Level source re-raises after EOI while still high
        do_reset();
        wr(2'd0, 32'h2);
        wr(2'd2, 32'h1);
        src[1] = 1'b1;
        cycle();
        cycle();
        chk("lvl_irq", irq, 1);
        chk("lvl_id", irq_id, 1);
        intack = 1'b1;
        cycle();
        intack = 1'b0;
        cycle();
        wr(2'd3, 32'h0);
        chk("lvl_eoi0", irq, 0);
        cycle();
        chk("lvl_rearm", irq, 1);
        intack = 1'b1;
        cycle();
        intack = 1'b0;
        src[1] = 1'b0;
        cycle();
        wr(2'd3, 32'h0);
        cycle();
        cycle();
        chk("lvl_dropped", irq, 0);

        // Priority preemption while requesting
        do_reset();
        wr(2'd0, 32'h5);
        wr(2'd2, 32'h0005_0001);
        src[2] = 1'b1;
        cycle();
        cycle();
        chk("pri_id2", irq_id, 2);
        src[0] = 1'b1;
        cycle();
        chk("pri_id0", irq_id, 0);
        intack = 1'b1;
        cycle();
        intack = 1'b0;
        rd_chk("pri_pend", 2'd1, 32'h4);
        rd_chk("pri_cur", 2'd3, 32'h0);
        wr(2'd3, 32'h0);
        cycle();
        chk("pri_next", irq_id, 2);
        chk("pri_next_irq", irq, 1);

        // Masking and global enable
        do_reset();
        wr(2'd2, 32'h0008_0001);
        src[3] = 1'b1;
        cycle();
        cycle();
        chk("msk_off", irq, 0);
        rd_chk("msk_pend", 2'd1, 32'h8);
        wr(2'd0, 32'h8);
        chk("msk_wait", irq, 0);
        cycle();
        chk("msk_on", irq, 1);
        wr(2'd2, 32'h0008_0000);
        cycle();
        chk("gie_off", irq, 0);

        // W1C against a same-cycle edge, plain W1C, W1C on a level bit
        do_reset();
        wr(2'd2, 32'h0001_0000);
        src[0] = 1'b1;
        wr(2'd1, 32'h1);
        rd_chk("w1c_set_wins", 2'd1, 32'h1);
        wr(2'd1, 32'h1);
        rd_chk("w1c_clear", 2'd1, 32'h0);
        src[1] = 1'b1;
        cycle();
        wr(2'd1, 32'h2);
        rd_chk("w1c_level", 2'd1, 32'h2);

        // Asynchronous reset during service
        do_reset();
        wr(2'd0, 32'h4);
        wr(2'd2, 32'h0004_0001);
        src[2] = 1'b1;
        cycle();
        cycle();
        intack = 1'b1;
        cycle();
        intack = 1'b0;
        chk("ar_svc_id", irq_id, 2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("ar_irq", irq, 0);
        chk("ar_id", irq_id, 0);
        for (int a = 0; a < 4; a++) rd_chk("ar_dout", 2'(a), 32'h0);
        src = '0;
        cycle();
        rst = 1'b1;
        cycle();
        for (int a = 0; a < 4; a++) rd_chk("ar_rel_dout", 2'(a), 32'h0);

        // Random traffic against the model
        do_reset();
        wr(2'd0, 32'h3F);
        wr(2'd2, 32'h0015_0001);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NSRC; i++) if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
            we = ($urandom_range(0, 7) == 0);
            addr = 2'($urandom_range(0, 3));
            din = $urandom;
            if (addr == 2'd2) din[0] = ($urandom_range(0, 5) != 0);
            if (addr == 2'd0 && $urandom_range(0, 1) == 0) din[NSRC-1:0] = '1;
            intack = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            cycle();
        end
        we = 1'b0;
        intack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller between the timer devices (and other bridge peripherals) and the multicycle CPU's exception logic.
- Collects up to NSRC interrupt requests, latches them as pending, applies per-source mask and a global enable, and picks the lowest-numbered pending source.
- Drives a single irq line to the CPU with an acknowledge / end-of-interrupt handshake.
- Memory-mapped on the bridge with the same 4-word register window as the timers.

Parameters:
- NSRC, 6, number of interrupt sources; legal range 1..8, source 0 has highest priority.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- addr  input  2 (bits [3:2])  register select.
- we  input  1  register write enable.
- din  input  32  write data.
- dout  output  32  read data, combinational from addr.
- src  input  NSRC  interrupt request lines (e.g. timer irq outputs), clk-synchronous.
- intack  input  1  one-cycle pulse from the CPU when it enters the exception handler.
- irq  output  1  interrupt request to the CPU.
- irq_id  output  3  number of the source being requested or serviced.

Behaviour:
- Register map (addr[3:2]):
  - 00 MASK: bits [NSRC-1:0] RW, 1 = enabled.
  - 01 PEND: read gives pend[NSRC-1:0]; write is W1C on edge-mode bits only.
  - 10 CFG: bit0 GIE RW; bits [NSRC+15:16] EDGE RW (1 = edge mode, 0 = level mode); bit1 in_service RO; bit2 req RO; bits [10:8] cur_id RO.
  - 11 EOI: any write ends service; read gives {29'b0, cur_id}.
  - Unused dout bits read 0.
- Reset (rst=0, async): MASK=0, EDGE=0, GIE=0, pend=0, src_prev=0, cur_id=0, state IDLE, irq=0, irq_id=0.
- Pending update, every posedge:
  - Edge source i: pend[i] sets when src[i]=1 and src_prev[i]=0.
  - Edge source i: pend[i] clears on a PEND W1C write with din[i]=1, or on intack capture of i. Set wins over a same-cycle clear.
  - Level source i: pend[i] <= src[i]; writes have no effect.
  - src_prev <= src.
- Eligible set: elig = pend & MASK, gated by GIE. best = lowest index with elig=1.
- FSM:
  - IDLE: if elig != 0, go to REQ on the next posedge.
  - REQ: irq=1 and irq_id=best, re-evaluated every cycle so a higher-priority arrival preempts the choice.
    - If elig becomes 0 (mask, GIE or W1C), return to IDLE; irq drops the following cycle.
    - On intack: cur_id <= best, clear pend[best] if it is edge mode, go to SERVICE.
  - SERVICE: irq=0 and irq_id=cur_id. New pending bits accumulate. No nesting.
    - A write to EOI returns to IDLE; re-arbitration happens next cycle.
- Outputs: irq=1 exactly when state is REQ. irq_id=best in REQ, cur_id otherwise.
- Latency: src edge sampled at posedge T → pend set after T → REQ after T+1. irq is first high in the cycle following T+1.
- Boundary cases:
  - intack outside REQ is ignored.
  - An EOI write outside SERVICE is ignored.
  - intack and a W1C clearing best in the same cycle: intack wins, and cur_id captures best.
  - MASK or GIE writes take effect for the next cycle's elig.
  - Reset asserted mid-SERVICE drops irq immediately and discards cur_id.
  - For a level source still high after EOI, the pending request re-raises irq: EOI at posedge E gives REQ after E+1.

Test Plan:
- Reset, then set MASK=0x01, GIE=1, EDGE=0x01. Pulse src[0] at posedge T → irq=1 from after T+1, irq_id=0. intack → irq=0, CFG[1]=1, PEND=0. EOI write → CFG[1]=0, irq stays 0.
- Level source: MASK=0x02, EDGE=0, src[1] held high (timer count==0). After intack and EOI → irq re-asserts 2 cycles after EOI. Drop src[1] before EOI → no re-assert.
- Priority: edge src[2] pends first and enters REQ (irq_id=2), then src[0] edges → irq_id switches to 0. intack → cur_id=0, PEND bit2 still 1. After EOI → irq_id=2.
- Masking: src[3] pending with MASK bit3=0 → irq stays 0, PEND reads 0x08. Write MASK=0x08 → irq=1 two cycles later. Clearing GIE while in REQ → irq=0 next cycle.
- W1C vs. set: write PEND=0x01 in the same cycle as a src[0] rising edge → PEND bit0 stays 1. W1C 0x01 with no edge → bit0 clears. W1C to a level bit → no change.
- Async reset: pull rst low mid-cycle during SERVICE → irq, irq_id and all registers 0 immediately. Release rst → state IDLE, dout=0 for every address.
